// File: rtl/mont_exp_sched.sv
// Left-to-right square-and-multiply exponentiation sequencer for a shared
// Montgomery multiplier. The accumulator and base are kept in Montgomery form.
// This block does no arithmetic on operands; every product comes from the
// external multiplier.
//
// Ports:
//   clk_in, rst_in          clock (rising edge) and asynchronous active-low reset
//   start_in                one-cycle run request, sampled only while idle
//   base_mont_in            base (a*R mod N), captured on an accepted start
//   one_mont_in             R mod N, captured on an accepted start
//   exp_in                  exponent, scanned MSB first, captured on an accepted start
//   mul_a_out, mul_b_out    multiplier operands, zero when no request is pending
//   mul_valid_out           multiplier request valid
//   mul_ready_in            multiplier accepts the request when valid && ready
//   mul_result_in           Montgomery product a*b*R^-1 mod N
//   mul_done_in             one-cycle response pulse, used only while waiting
//   busy_out                high whenever a run is in progress
//   result_out              final accumulator, held until the next completion
//   done_out                one-cycle pulse when result_out is updated
//   op_count_out            multiplier requests issued this run (saturating)
module mont_exp_sched #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EXP_WIDTH = 512,
    parameter int unsigned CNT_WIDTH = 11
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    input  logic [WIDTH-1:0]     base_mont_in,
    input  logic [WIDTH-1:0]     one_mont_in,
    input  logic [EXP_WIDTH-1:0] exp_in,
    output logic [WIDTH-1:0]     mul_a_out,
    output logic [WIDTH-1:0]     mul_b_out,
    output logic                 mul_valid_out,
    input  logic                 mul_ready_in,
    input  logic [WIDTH-1:0]     mul_result_in,
    input  logic                 mul_done_in,
    output logic                 busy_out,
    output logic [WIDTH-1:0]     result_out,
    output logic                 done_out,
    output logic [CNT_WIDTH-1:0] op_count_out
);

    localparam int unsigned IDX_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(EXP_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SCAN     = 3'd1,
        SQ_REQ   = 3'd2,
        SQ_WAIT  = 3'd3,
        MUL_REQ  = 3'd4,
        MUL_WAIT = 3'd5,
        FINISH   = 3'd6
    } state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       acc_q;
    logic [WIDTH-1:0]       base_q;
    logic [WIDTH-1:0]       one_q;
    logic [EXP_WIDTH-1:0]   exp_q;
    logic [IDX_W-1:0]       idx_q;
    logic [CNT_WIDTH-1:0]   op_count_q;
    logic [WIDTH-1:0]       mul_a_q;
    logic [WIDTH-1:0]       mul_b_q;
    logic                   mul_valid_q;
    logic                   busy_q;
    logic [WIDTH-1:0]       result_q;
    logic                   done_q;

    // Helpers shared by several states
    logic                   cur_bit_c;
    logic                   idx_last_c;
    logic                   handshake_c;
    logic [CNT_WIDTH-1:0]   cnt_inc_c;
    logic [IDX_W-1:0]       idx_dec_c;

    assign cur_bit_c   = exp_q[idx_q];
    assign idx_last_c  = (idx_q == '0);
    assign handshake_c = mul_valid_q && mul_ready_in;
    assign cnt_inc_c   = (op_count_q == '1) ? op_count_q : op_count_q + CNT_WIDTH'(1);
    assign idx_dec_c   = idx_q - IDX_W'(1);

    // Sequencer: operands and valid are loaded on entry to a *_REQ state so
    // they are registered and stay stable until the handshake completes.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            one_q       <= '0;
            exp_q       <= '0;
            idx_q       <= '0;
            op_count_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            result_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        base_q     <= base_mont_in;
                        one_q      <= one_mont_in;
                        exp_q      <= exp_in;
                        idx_q      <= IDX_TOP;
                        op_count_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end

                // Skip leading zeros; the first set bit seeds acc with base.
                SCAN: begin
                    if (cur_bit_c) begin
                        acc_q <= base_q;
                        if (idx_last_c) begin
                            result_q <= base_q;
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end else begin
                            idx_q       <= idx_dec_c;
                            mul_a_q     <= base_q;
                            mul_b_q     <= base_q;
                            mul_valid_q <= 1'b1;
                            state_q     <= SQ_REQ;
                        end
                    end else if (idx_last_c) begin
                        acc_q    <= one_q;
                        result_q <= one_q;
                        done_q   <= 1'b1;
                        state_q  <= FINISH;
                    end else begin
                        idx_q <= idx_dec_c;
                    end
                end

                SQ_REQ, MUL_REQ: begin
                    if (handshake_c) begin
                        mul_valid_q <= 1'b0;
                        mul_a_q     <= '0;
                        mul_b_q     <= '0;
                        op_count_q  <= cnt_inc_c;
                        state_q     <= (state_q == SQ_REQ) ? SQ_WAIT : MUL_WAIT;
                    end
                end

                // After a square the current bit decides whether to multiply.
                SQ_WAIT: begin
                    if (mul_done_in) begin
                        acc_q <= mul_result_in;
                        if (cur_bit_c) begin
                            mul_a_q     <= mul_result_in;
                            mul_b_q     <= base_q;
                            mul_valid_q <= 1'b1;
                            state_q     <= MUL_REQ;
                        end else if (idx_last_c) begin
                            result_q <= mul_result_in;
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end else begin
                            idx_q       <= idx_dec_c;
                            mul_a_q     <= mul_result_in;
                            mul_b_q     <= mul_result_in;
                            mul_valid_q <= 1'b1;
                            state_q     <= SQ_REQ;
                        end
                    end
                end

                MUL_WAIT: begin
                    if (mul_done_in) begin
                        acc_q <= mul_result_in;
                        if (idx_last_c) begin
                            result_q <= mul_result_in;
                            done_q   <= 1'b1;
                            state_q  <= FINISH;
                        end else begin
                            idx_q       <= idx_dec_c;
                            mul_a_q     <= mul_result_in;
                            mul_b_q     <= mul_result_in;
                            mul_valid_q <= 1'b1;
                            state_q     <= SQ_REQ;
                        end
                    end
                end

                // done_out is high for this single cycle.
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mul_a_out     = mul_a_q;
    assign mul_b_out     = mul_b_q;
    assign mul_valid_out = mul_valid_q;
    assign busy_out      = busy_q;
    assign result_out    = result_q;
    assign done_out      = done_q;
    assign op_count_out  = op_count_q;

endmodule
